// File: rtl/otter_decode_stage.sv
// -----------------------------------------------------------------------------
// otter_decode_stage
//
// Decode stage of the pipelined OTTER core. Each cycle one RV32I instruction
// (optionally RV32M) arriving from fetch is decoded into a control word that
// is captured in the decode/execute (EX) register. The stage also raises a
// load-use interlock against the instruction sitting in EX, and resolves the
// PC source for the EX instruction from the branch comparator results.
//
// Parameters
//   ALU_FUN_W  width of ALU_FUN (>=4; must be 5 when EN_M=1)
//   EN_M       1 = RV32M OP encodings are legal and decoded
//   HAZARD_EN  1 = load-use interlock active; 0 = never interlock
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   IF_VALID, IR             instruction from fetch and its valid flag
//   EX_STALL                 execute cannot accept; EX register holds
//   FLUSH                    squash the instruction being loaded into EX
//   BR_EQ, BR_LT, BR_LTU     comparator results for the EX instruction
//   DE_READY                 IR consumed this cycle (combinational)
//   EX_VALID, ILLEGAL        EX register holds a live / an illegal instruction
//   ALU_FUN, ALU_SRCA, ALU_SRCB, RF_WR_SEL, RF_WE, MEM_WE, MEM_RE, EX_RD
//                            registered control word for execute
//   PC_SOURCE                0=PC+4, 1=JALR, 2=branch, 3=JAL (combinational)
// -----------------------------------------------------------------------------
module otter_decode_stage #(
    parameter int ALU_FUN_W = 4,
    parameter int EN_M      = 0,
    parameter int HAZARD_EN = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IF_VALID,
    input  logic [31:0]          IR,
    input  logic                 EX_STALL,
    input  logic                 FLUSH,
    input  logic                 BR_EQ,
    input  logic                 BR_LT,
    input  logic                 BR_LTU,
    output logic                 DE_READY,
    output logic                 EX_VALID,
    output logic [ALU_FUN_W-1:0] ALU_FUN,
    output logic                 ALU_SRCA,
    output logic [1:0]           ALU_SRCB,
    output logic [1:0]           RF_WR_SEL,
    output logic                 RF_WE,
    output logic                 MEM_WE,
    output logic                 MEM_RE,
    output logic [4:0]           EX_RD,
    output logic [1:0]           PC_SOURCE,
    output logic                 ILLEGAL
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // Instruction class the EX stage needs to pick a PC source.
    typedef enum logic [1:0] {
        KIND_NONE   = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JAL    = 2'd2,
        KIND_JALR   = 2'd3
    } kind_e;

    // Branch condition from funct3 and the comparator flags. The reserved
    // funct3 values never reach EX as a branch, so they fall to not-taken.
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq,
                                          input logic lt, input logic ltu);
        case (f3)
            3'b000:  return eq;
            3'b001:  return ~eq;
            3'b100:  return lt;
            3'b101:  return ~lt;
            3'b110:  return ltu;
            3'b111:  return ~ltu;
            default: return 1'b0;
        endcase
    endfunction

    // The decoder works with a 5-bit function code internally; the port is
    // the zero-extended (or, with EN_M=0 and a 4-bit port, exact) view.
    function automatic logic [ALU_FUN_W-1:0] fit_fun(input logic [4:0] f);
        return ALU_FUN_W'(f);
    endfunction

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;

    assign opcode = IR[6:0];
    assign rd     = IR[11:7];
    assign f3     = IR[14:12];
    assign rs1    = IR[19:15];
    assign rs2    = IR[24:20];
    assign f7     = IR[31:25];

    // ---- stage p0: combinational decode of IR ----
    logic [4:0] fun_p0;
    logic       srca_p0;
    logic [1:0] srcb_p0;
    logic [1:0] wr_sel_p0;
    logic       rf_we_p0;
    logic       mem_we_p0;
    logic       mem_re_p0;
    logic [4:0] rd_p0;
    logic [2:0] f3_p0;
    kind_e      kind_p0;
    logic       bad_p0;

    always_comb begin
        fun_p0    = 5'd0;
        srca_p0   = 1'b0;
        srcb_p0   = 2'd0;
        wr_sel_p0 = 2'd0;
        rf_we_p0  = 1'b0;
        mem_we_p0 = 1'b0;
        mem_re_p0 = 1'b0;
        kind_p0   = KIND_NONE;
        bad_p0    = (IR[1:0] != 2'b11);
        rd_p0     = rd;
        f3_p0     = f3;

        case (opcode)
            OP_LUI: begin
                fun_p0    = 5'd9;
                srca_p0   = 1'b1;
                wr_sel_p0 = 2'd3;
                rf_we_p0  = 1'b1;
            end
            OP_AUIPC: begin
                srca_p0   = 1'b1;
                srcb_p0   = 2'd3;
                wr_sel_p0 = 2'd3;
                rf_we_p0  = 1'b1;
            end
            OP_JAL: begin
                rf_we_p0 = 1'b1;
                kind_p0  = KIND_JAL;
            end
            OP_JALR: begin
                rf_we_p0 = 1'b1;
                kind_p0  = KIND_JALR;
            end
            OP_LOAD: begin
                srcb_p0   = 2'd1;
                wr_sel_p0 = 2'd2;
                rf_we_p0  = 1'b1;
                mem_re_p0 = 1'b1;
            end
            OP_STORE: begin
                srcb_p0   = 2'd2;
                mem_we_p0 = 1'b1;
            end
            OP_BRANCH: begin
                kind_p0 = KIND_BRANCH;
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    bad_p0 = 1'b1;
                end
            end
            OP_OPIMM: begin
                // Only the shift-right immediates carry f7[5] into the code.
                fun_p0    = (f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
                srcb_p0   = 2'd1;
                wr_sel_p0 = 2'd3;
                rf_we_p0  = 1'b1;
                if (f3 == 3'b001 && f7 != F7_ZERO) begin
                    bad_p0 = 1'b1;
                end
                if (f3 == 3'b101 && f7 != F7_ZERO && f7 != F7_ALT) begin
                    bad_p0 = 1'b1;
                end
            end
            OP_OP: begin
                wr_sel_p0 = 2'd3;
                rf_we_p0  = 1'b1;
                if (EN_M != 0 && f7 == F7_MUL) begin
                    fun_p0 = {2'b10, f3};
                end else begin
                    fun_p0 = {1'b0, f7[5], f3};
                end
                if (f7 == F7_ALT) begin
                    // Only SUB and SRA have an alternate-f7 form.
                    if (f3 != 3'b000 && f3 != 3'b101) begin
                        bad_p0 = 1'b1;
                    end
                end else if (f7 != F7_ZERO && !(EN_M != 0 && f7 == F7_MUL)) begin
                    bad_p0 = 1'b1;
                end
            end
            default: begin
                bad_p0 = 1'b1;
            end
        endcase

        if (rd == 5'd0) begin
            rf_we_p0 = 1'b0;
        end

        // An illegal instruction travels down as an inert control word.
        if (bad_p0) begin
            fun_p0    = 5'd0;
            srca_p0   = 1'b0;
            srcb_p0   = 2'd0;
            wr_sel_p0 = 2'd0;
            rf_we_p0  = 1'b0;
            mem_we_p0 = 1'b0;
            mem_re_p0 = 1'b0;
            kind_p0   = KIND_NONE;
            rd_p0     = 5'd0;
            f3_p0     = 3'd0;
        end
    end

    // Register operands actually read by the instruction in IR.
    logic use_rs1;
    logic use_rs2;

    always_comb begin
        use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        use_rs2 = (opcode == OP_BRANCH || opcode == OP_STORE || opcode == OP_OP);
    end

    // ---- stage p1: EX register ----
    logic                 vld_p1;
    logic [ALU_FUN_W-1:0] fun_p1;
    logic                 srca_p1;
    logic [1:0]           srcb_p1;
    logic [1:0]           wr_sel_p1;
    logic                 rf_we_p1;
    logic                 mem_we_p1;
    logic                 mem_re_p1;
    logic [4:0]           rd_p1;
    logic [2:0]           f3_p1;
    kind_e                kind_p1;
    logic                 illegal_p1;

    // A load in EX whose destination the IR instruction reads cannot forward
    // in time; hold IR one cycle and let a bubble go down instead.
    logic hazard;

    always_comb begin
        hazard = (HAZARD_EN != 0) && vld_p1 && mem_re_p1 && (rd_p1 != 5'd0) &&
                 IF_VALID && ((use_rs1 && rs1 == rd_p1) || (use_rs2 && rs2 == rd_p1));
    end

    assign DE_READY = ~EX_STALL & ~hazard;

    always_ff @(posedge CLK) begin
        if (RST || FLUSH || (!EX_STALL && (hazard || !IF_VALID))) begin
            // Reset, squash, bubble and empty fetch all leave EX empty.
            // FLUSH sits ahead of EX_STALL on purpose: a wrong-path
            // instruction must not be kept alive by a stall.
            vld_p1     <= 1'b0;
            fun_p1     <= '0;
            srca_p1    <= 1'b0;
            srcb_p1    <= 2'd0;
            wr_sel_p1  <= 2'd0;
            rf_we_p1   <= 1'b0;
            mem_we_p1  <= 1'b0;
            mem_re_p1  <= 1'b0;
            rd_p1      <= 5'd0;
            f3_p1      <= 3'd0;
            kind_p1    <= KIND_NONE;
            illegal_p1 <= 1'b0;
        end else if (!EX_STALL) begin
            vld_p1     <= 1'b1;
            fun_p1     <= fit_fun(fun_p0);
            srca_p1    <= srca_p0;
            srcb_p1    <= srcb_p0;
            wr_sel_p1  <= wr_sel_p0;
            rf_we_p1   <= rf_we_p0;
            mem_we_p1  <= mem_we_p0;
            mem_re_p1  <= mem_re_p0;
            rd_p1      <= rd_p0;
            f3_p1      <= f3_p0;
            kind_p1    <= kind_p0;
            illegal_p1 <= bad_p0;
        end
    end

    assign EX_VALID  = vld_p1;
    assign ALU_FUN   = fun_p1;
    assign ALU_SRCA  = srca_p1;
    assign ALU_SRCB  = srcb_p1;
    assign RF_WR_SEL = wr_sel_p1;
    assign RF_WE     = rf_we_p1;
    assign MEM_WE    = mem_we_p1;
    assign MEM_RE    = mem_re_p1;
    assign EX_RD     = rd_p1;
    assign ILLEGAL   = illegal_p1;

    // PC source follows the EX instruction with no added latency.
    always_comb begin
        PC_SOURCE = 2'd0;
        if (vld_p1 && !illegal_p1) begin
            case (kind_p1)
                KIND_JAL:    PC_SOURCE = 2'd3;
                KIND_JALR:   PC_SOURCE = 2'd1;
                KIND_BRANCH: PC_SOURCE = branch_taken(f3_p1, BR_EQ, BR_LT, BR_LTU) ? 2'd2 : 2'd0;
                default:     PC_SOURCE = 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_otter_decode_stage
//
// Three instances share one stimulus stream:
//   0: ALU_FUN_W=4, EN_M=0, HAZARD_EN=1
//   1: ALU_FUN_W=5, EN_M=1, HAZARD_EN=1
//   2: ALU_FUN_W=4, EN_M=0, HAZARD_EN=0
// Each has its own reference EX state in the bench, derived from the
// instruction-set rules. A directed sequence is followed by random traffic.
// -----------------------------------------------------------------------------
module tb_otter_decode_stage;

    logic        CLK = 1'b0;
    logic        RST, IF_VALID, EX_STALL, FLUSH, BR_EQ, BR_LT, BR_LTU;
    logic [31:0] IR;

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    logic       rdy   [3];
    logic       vld   [3];
    logic       srca  [3];
    logic [1:0] srcb  [3];
    logic [1:0] wrsel [3];
    logic       rfwe  [3];
    logic       memwe [3];
    logic       memre [3];
    logic [4:0] rd    [3];
    logic [1:0] pcs   [3];
    logic       ill   [3];
    logic [3:0] fun0, fun2;
    logic [4:0] fun1;

    otter_decode_stage #(.ALU_FUN_W(4), .EN_M(0), .HAZARD_EN(1)) u_dut0 (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IR(IR), .EX_STALL(EX_STALL),
        .FLUSH(FLUSH), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
        .DE_READY(rdy[0]), .EX_VALID(vld[0]), .ALU_FUN(fun0), .ALU_SRCA(srca[0]),
        .ALU_SRCB(srcb[0]), .RF_WR_SEL(wrsel[0]), .RF_WE(rfwe[0]), .MEM_WE(memwe[0]),
        .MEM_RE(memre[0]), .EX_RD(rd[0]), .PC_SOURCE(pcs[0]), .ILLEGAL(ill[0]));

    otter_decode_stage #(.ALU_FUN_W(5), .EN_M(1), .HAZARD_EN(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IR(IR), .EX_STALL(EX_STALL),
        .FLUSH(FLUSH), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
        .DE_READY(rdy[1]), .EX_VALID(vld[1]), .ALU_FUN(fun1), .ALU_SRCA(srca[1]),
        .ALU_SRCB(srcb[1]), .RF_WR_SEL(wrsel[1]), .RF_WE(rfwe[1]), .MEM_WE(memwe[1]),
        .MEM_RE(memre[1]), .EX_RD(rd[1]), .PC_SOURCE(pcs[1]), .ILLEGAL(ill[1]));

    otter_decode_stage #(.ALU_FUN_W(4), .EN_M(0), .HAZARD_EN(0)) u_dut2 (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IR(IR), .EX_STALL(EX_STALL),
        .FLUSH(FLUSH), .BR_EQ(BR_EQ), .BR_LT(BR_LT), .BR_LTU(BR_LTU),
        .DE_READY(rdy[2]), .EX_VALID(vld[2]), .ALU_FUN(fun2), .ALU_SRCA(srca[2]),
        .ALU_SRCB(srcb[2]), .RF_WR_SEL(wrsel[2]), .RF_WE(rfwe[2]), .MEM_WE(memwe[2]),
        .MEM_RE(memre[2]), .EX_RD(rd[2]), .PC_SOURCE(pcs[2]), .ILLEGAL(ill[2]));

    // kind: 0 other, 1 branch, 2 jal, 3 jalr
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic [4:0] fun;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] wrsel;
        logic       rfwe;
        logic       memwe;
        logic       memre;
        logic [4:0] rd;
        logic [1:0] kind;
        logic [2:0] f3;
    } ctl_t;

    ctl_t ex_m [3];

    function automatic bit en_m_of(int i);
        return (i == 1);
    endfunction

    function automatic bit haz_of(int i);
        return (i != 2);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction-set rules.
    function automatic ctl_t ref_decode(logic [31:0] ir, bit en_m);
        ctl_t       c;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         legal;
        c     = '0;
        op    = ir[6:0];
        f3    = ir[14:12];
        f7    = ir[31:25];
        legal = (ir[1:0] == 2'b11);
        c.valid = 1'b1;
        c.rd    = ir[11:7];
        c.f3    = f3;
        case (op)
            7'h37: begin c.fun = 5'd9; c.srca = 1; c.wrsel = 2'd3; c.rfwe = 1; end
            7'h17: begin c.srca = 1; c.srcb = 2'd3; c.wrsel = 2'd3; c.rfwe = 1; end
            7'h6F: begin c.wrsel = 2'd0; c.rfwe = 1; c.kind = 2'd2; end
            7'h67: begin c.wrsel = 2'd0; c.rfwe = 1; c.kind = 2'd3; end
            7'h03: begin c.srcb = 2'd1; c.wrsel = 2'd2; c.rfwe = 1; c.memre = 1; end
            7'h23: begin c.srcb = 2'd2; c.memwe = 1; end
            7'h63: begin c.kind = 2'd1; if (f3 == 2 || f3 == 3) legal = 0; end
            7'h13: begin
                c.fun   = (f3 == 5) ? 5'(int'(f7[5]) * 8 + int'(f3)) : 5'(f3);
                c.srcb  = 2'd1; c.wrsel = 2'd3; c.rfwe = 1;
                if (f3 == 1 && f7 != 0) legal = 0;
                if (f3 == 5 && !(f7 == 7'h00 || f7 == 7'h20)) legal = 0;
            end
            7'h33: begin
                c.wrsel = 2'd3; c.rfwe = 1;
                if (en_m && f7 == 7'h01) c.fun = 5'(16 + int'(f3));
                else                     c.fun = 5'(int'(f7[5]) * 8 + int'(f3));
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) ||
                      (en_m && f7 == 7'h01))) legal = 0;
            end
            default: legal = 0;
        endcase
        if (c.rd == 0) c.rfwe = 0;
        if (!legal) begin
            c = '0;
            c.valid   = 1'b1;
            c.illegal = 1'b1;
        end
        return c;
    endfunction

    function automatic bit ref_hazard(int i);
        logic [6:0] op;
        bit u1, u2;
        op = IR[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
        return haz_of(i) && ex_m[i].valid && ex_m[i].memre && (ex_m[i].rd != 0) && IF_VALID &&
               ((u1 && IR[19:15] == ex_m[i].rd) || (u2 && IR[24:20] == ex_m[i].rd));
    endfunction

    function automatic logic [1:0] ref_pcs(int i);
        ctl_t c;
        bit   t;
        c = ex_m[i];
        if (!c.valid || c.illegal) return 2'd0;
        case (c.kind)
            2'd2: return 2'd3;
            2'd3: return 2'd1;
            2'd1: begin
                case (c.f3)
                    3'd0: t = BR_EQ;
                    3'd1: t = !BR_EQ;
                    3'd4: t = BR_LT;
                    3'd5: t = !BR_LT;
                    3'd6: t = BR_LTU;
                    3'd7: t = !BR_LTU;
                    default: t = 0;
                endcase
                return t ? 2'd2 : 2'd0;
            end
            default: return 2'd0;
        endcase
    endfunction

    task automatic check_all();
        logic [4:0]  f;
        logic [19:0] obs, exp;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       f = {1'b0, fun0};
                1:       f = fun1;
                default: f = {1'b0, fun2};
            endcase
            obs = {vld[i], ill[i], f, srca[i], srcb[i], wrsel[i], rfwe[i], memwe[i], memre[i], rd[i]};
            exp = {ex_m[i].valid, ex_m[i].illegal, ex_m[i].fun, ex_m[i].srca, ex_m[i].srcb,
                   ex_m[i].wrsel, ex_m[i].rfwe, ex_m[i].memwe, ex_m[i].memre, ex_m[i].rd};
            check_val($sformatf("ctl%0d", i), 32'(obs), 32'(exp));
            check_val($sformatf("rdy%0d", i), 32'(rdy[i]), 32'(!EX_STALL && !ref_hazard(i)));
            check_val($sformatf("pcs%0d", i), 32'(pcs[i]), 32'(ref_pcs(i)));
        end
    endtask

    // One clock: advance the reference models on the edge, then compare.
    task automatic tick();
        bit hz [3];
        for (int i = 0; i < 3; i++) hz[i] = ref_hazard(i);
        @(posedge CLK);
        for (int i = 0; i < 3; i++) begin
            if (RST || FLUSH)       ex_m[i] = '0;
            else if (EX_STALL)      ex_m[i] = ex_m[i];
            else if (hz[i])         ex_m[i] = '0;
            else if (IF_VALID)      ex_m[i] = ref_decode(IR, en_m_of(i));
            else                    ex_m[i] = '0;
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rdv, r1, r2;
        case ($urandom_range(0, 9))
            0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
            4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
            8: op = 7'h33;
            default: return $urandom();
        endcase
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom_range(0, 127));
        endcase
        f3  = 3'($urandom_range(0, 7));
        rdv = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        return {f7, r2, r1, f3, rdv, op};
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) ex_m[i] = '0;
        RST = 1; IF_VALID = 1; IR = 32'h00500093;
        EX_STALL = 0; FLUSH = 0; BR_EQ = 0; BR_LT = 0; BR_LTU = 0;

        // Reset with ADDI x1,x0,5 waiting in IR.
        tick();
        tick();
        check_val("rst_vld", 32'(vld[0]), 32'd0);
        check_val("rst_rdy", 32'(rdy[0]), 32'd1);
        RST = 0;
        tick();
        check_val("addi_vld",  32'(vld[0]), 32'd1);
        check_val("addi_fun",  32'(fun0), 32'd0);
        check_val("addi_srcb", 32'(srcb[0]), 32'd1);
        check_val("addi_wsel", 32'(wrsel[0]), 32'd3);
        check_val("addi_we",   32'(rfwe[0]), 32'd1);
        check_val("addi_rd",   32'(rd[0]), 32'd1);

        // SUB x2,x1,x2
        IR = 32'h40208133;
        tick();
        check_val("sub_fun",  32'(fun0), 32'd8);
        check_val("sub_srcb", 32'(srcb[0]), 32'd0);
        check_val("sub_we",   32'(rfwe[0]), 32'd1);
        check_val("sub_rd",   32'(rd[0]), 32'd2);

        // BGE x1,x2 held in EX while the comparator flags change.
        IR = 32'h0020D463;
        tick();
        EX_STALL = 1; BR_EQ = 1; BR_LT = 0;
        #1; check_all();
        check_val("bge_taken", 32'(pcs[0]), 32'd2);
        BR_LT = 1;
        #1; check_all();
        check_val("bge_not", 32'(pcs[0]), 32'd0);
        FLUSH = 1;
        tick();
        check_val("flush_vld", 32'(vld[0]), 32'd0);
        FLUSH = 0; EX_STALL = 0; BR_EQ = 0; BR_LT = 0;

        // lw x5,0(x1) then add x6,x5,x0
        IR = 32'h0000A283;
        tick();
        IR = 32'h00028333;
        #1; check_all();
        check_val("lu_rdy_hz",  32'(rdy[0]), 32'd0);
        check_val("lu_rdy_nhz", 32'(rdy[2]), 32'd1);
        tick();
        check_val("lu_bubble",  32'(vld[0]), 32'd0);
        check_val("lu_rdy_rel", 32'(rdy[0]), 32'd1);
        check_val("nh_add_vld", 32'(vld[2]), 32'd1);
        check_val("nh_add_rd",  32'(rd[2]), 32'd6);
        tick();
        check_val("lu_add_vld", 32'(vld[0]), 32'd1);
        check_val("lu_add_rd",  32'(rd[0]), 32'd6);

        // Stall three cycles while IR keeps changing.
        EX_STALL = 1;
        for (int k = 0; k < 3; k++) begin
            IR = rand_ir();
            tick();
            check_val("stall_rdy", 32'(rdy[0]), 32'd0);
            check_val("stall_rd",  32'(rd[0]), 32'd6);
        end
        EX_STALL = 0;

        // Illegal encodings and the M extension.
        IR = 32'hFFFFFFFF;
        tick();
        check_val("ill_flag", 32'(ill[0]), 32'd1);
        check_val("ill_vld",  32'(vld[0]), 32'd1);
        check_val("ill_we",   32'(rfwe[0]), 32'd0);
        check_val("ill_mwe",  32'(memwe[0]), 32'd0);
        check_val("ill_pcs",  32'(pcs[0]), 32'd0);
        IR = 32'h023100B3;
        tick();
        check_val("mul_ill_nom", 32'(ill[0]), 32'd1);
        check_val("mul_ill_m",   32'(ill[1]), 32'd0);
        check_val("mul_fun",     32'(fun1), 32'd16);
        check_val("mul_we",      32'(rfwe[1]), 32'd1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            RST      = ($urandom_range(0, 63) == 0);
            FLUSH    = ($urandom_range(0, 15) == 0);
            EX_STALL = ($urandom_range(0, 7) == 0);
            IF_VALID = ($urandom_range(0, 7) != 0);
            BR_EQ    = 1'($urandom_range(0, 1));
            BR_LT    = 1'($urandom_range(0, 1));
            BR_LTU   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) IR = rand_ir();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
